// File: rtl/l2_if_pkg.sv
// l2_if_pkg: shared types for the L2 responder.
//   l2_req_t   : request record {rw, addr, wdata} at the default widths.
//   l2_state_e : responder FSM state encodings.
//   RW_READ/RW_WB : values of the L1 rw_l2 line.
package l2_if_pkg;

  localparam int unsigned L2_ADDR_W = 32;
  localparam int unsigned L2_LINE_W = 256;

  localparam logic RW_READ = 1'b0;
  localparam logic RW_WB   = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_RESPOND = 2'd2
  } l2_state_e;

  typedef struct packed {
    logic                 rw;
    logic [L2_ADDR_W-1:0] addr;
    logic [L2_LINE_W-1:0] wdata;
  } l2_req_t;

endpackage

// File: rtl/l2_req_fifo.sv
// l2_req_fifo: show-ahead synchronous FIFO holding queued L1 requests.
// Ports:
//   clock, reset (async, active-low)
//   push / wr_data : enqueue (ignored when full)
//   pop            : dequeue head (ignored when empty)
//   rd_data        : current head entry
//   full, empty, count : occupancy status; count is clog2(DEPTH)+1 bits
// Pointers wrap modulo DEPTH (DEPTH must be a power of 2, >= 2).
module l2_req_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push & ~full;
    do_pop   = pop & ~empty;
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; validity is tracked by the pointers.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/l2_responder_fsm.sv
// l2_responder_fsm: L2-side responder for the L1 miss interface.
// Queues L1 line reads and dirty writebacks in order, services them one at a
// time on the backing memory port, and returns read fills with a one-cycle
// done_l2 pulse. stall_l2 is registered and back-pressures L1 when full.
// Ports:
//   clock, reset (async, active-low)
//   L1 side : valid_l2, rw_l2, addr_l2, wdata_l2 -> stall_l2, done_l2,
//             done_addr, rdata_l2
//   Memory  : mem_req, mem_we, mem_addr, mem_wdata -> mem_ack, mem_rdata
// Build option L2_WB_FORWARD_EN: a read whose address matches the most
// recently completed writeback is answered from that writeback's data
// without a memory access.
module l2_responder_fsm
  import l2_if_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LINE_W = 256,
  parameter int unsigned QDEPTH = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              valid_l2,
  input  logic              rw_l2,
  input  logic [ADDR_W-1:0] addr_l2,
  input  logic [LINE_W-1:0] wdata_l2,
  output logic              stall_l2,
  output logic              done_l2,
  output logic [ADDR_W-1:0] done_addr,
  output logic [LINE_W-1:0] rdata_l2,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [LINE_W-1:0] mem_rdata
);

  localparam int unsigned REQ_W = 1 + ADDR_W + LINE_W;
  localparam int unsigned CNT_W = $clog2(QDEPTH) + 1;

  l2_state_e         state_q, state_d;
  logic              stall_q, stall_d;
  logic [LINE_W-1:0] rdata_q, rdata_d;
  logic [ADDR_W-1:0] done_addr_q, done_addr_d;

  logic              push, pop;
  logic              fifo_full, fifo_empty;
  logic [CNT_W-1:0]  fifo_count, count_next;
  logic [REQ_W-1:0]  head;
  logic              head_rw;
  logic [ADDR_W-1:0] head_addr;
  logic [LINE_W-1:0] head_wdata;
  logic              fwd_hit;
  logic [LINE_W-1:0] fwd_data;

  assign push       = valid_l2 & ~stall_q & ~fifo_full;
  assign head_rw    = head[REQ_W-1];
  assign head_addr  = head[LINE_W +: ADDR_W];
  assign head_wdata = head[LINE_W-1:0];
  assign stall_l2   = stall_q;

  l2_req_fifo #(
    .WIDTH (REQ_W),
    .DEPTH (QDEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push    (push),
    .wr_data ({rw_l2, addr_l2, wdata_l2}),
    .pop     (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

`ifdef L2_WB_FORWARD_EN
  logic              fwd_vld_q, fwd_vld_d;
  logic [ADDR_W-1:0] fwd_addr_q, fwd_addr_d;
  logic [LINE_W-1:0] fwd_data_q, fwd_data_d;

  assign fwd_hit  = fwd_vld_q & (head_rw == RW_READ) & (head_addr == fwd_addr_q);
  assign fwd_data = fwd_data_q;

  // Remember the newest writeback as it retires; later writebacks overwrite it.
  always_comb begin
    fwd_vld_d  = fwd_vld_q;
    fwd_addr_d = fwd_addr_q;
    fwd_data_d = fwd_data_q;
    if (pop && head_rw == RW_WB) begin
      fwd_vld_d  = 1'b1;
      fwd_addr_d = head_addr;
      fwd_data_d = head_wdata;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) fwd_vld_q <= 1'b0;
    else        fwd_vld_q <= fwd_vld_d;
  end

  always_ff @(posedge clock) begin
    fwd_addr_q <= fwd_addr_d;
    fwd_data_q <= fwd_data_d;
  end
`else
  assign fwd_hit  = 1'b0;
  assign fwd_data = '0;
`endif

  // Outputs are decoded from the state so an async reset or an illegal
  // encoding forces every output low immediately.
  always_comb begin
    state_d     = state_q;
    rdata_d     = rdata_q;
    done_addr_d = done_addr_q;
    pop         = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    done_l2     = 1'b0;
    done_addr   = '0;
    rdata_l2    = '0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (!fwd_hit) begin
          mem_req   = 1'b1;
          mem_we    = head_rw;
          mem_addr  = head_addr;
          mem_wdata = head_wdata;
        end
        if (fwd_hit || mem_ack) begin
          pop = 1'b1;
          if (head_rw == RW_READ) begin
            state_d     = ST_RESPOND;
            rdata_d     = fwd_hit ? fwd_data : mem_rdata;
            done_addr_d = head_addr;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_RESPOND: begin
        done_l2   = 1'b1;
        done_addr = done_addr_q;
        rdata_l2  = rdata_q;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Stall reflects occupancy after the coming edge, so it rises with the
  // filling accept and falls the cycle after a pop frees a slot.
  always_comb begin
    count_next = fifo_count + CNT_W'(push) - CNT_W'(pop);
    stall_d    = (count_next == CNT_W'(QDEPTH));
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      stall_q <= 1'b0;
    end else begin
      state_q <= state_d;
      stall_q <= stall_d;
    end
  end

  // Fill data registers are only visible through RESPOND, so they need no reset.
  always_ff @(posedge clock) begin
    rdata_q     <= rdata_d;
    done_addr_q <= done_addr_d;
  end

endmodule

// File: tb/tb_l2_responder_fsm.sv
// Directed bench for l2_responder_fsm with a small backing-memory model.
module tb_l2_responder_fsm;

  logic         clock;
  logic         reset;
  logic         valid_l2;
  logic         rw_l2;
  logic [31:0]  addr_l2;
  logic [255:0] wdata_l2;
  logic         stall_l2;
  logic         done_l2;
  logic [31:0]  done_addr;
  logic [255:0] rdata_l2;
  logic         mem_req;
  logic         mem_we;
  logic [31:0]  mem_addr;
  logic [255:0] mem_wdata;
  logic         mem_ack;
  logic [255:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  logic         ack_force = 1'b0;
  logic         ack_rand  = 1'b0;
  int           wait_cnt  = 0;
  int           cur_delay = 2;
  logic [255:0] mem_arr [16];
  logic [15:0]  wr_mask = '0;
  logic [31:0]  exp_q [$];

  l2_responder_fsm #(
    .ADDR_W (32),
    .LINE_W (256),
    .QDEPTH (4)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .valid_l2  (valid_l2),
    .rw_l2     (rw_l2),
    .addr_l2   (addr_l2),
    .wdata_l2  (wdata_l2),
    .stall_l2  (stall_l2),
    .done_l2   (done_l2),
    .done_addr (done_addr),
    .rdata_l2  (rdata_l2),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [255:0] pat(input logic [31:0] a);
    return {8{a ^ 32'hC0DE_0000}};
  endfunction

  function automatic logic [255:0] exp_rd(input logic [31:0] a);
    return wr_mask[a[7:4]] ? mem_arr[a[7:4]] : pat(a);
  endfunction

  assign mem_rdata = wr_mask[mem_addr[7:4]] ? mem_arr[mem_addr[7:4]] : pat(mem_addr);
  assign mem_ack   = ack_force | (ack_rand & mem_req & (wait_cnt >= cur_delay));

  always @(posedge clock) begin
    if (mem_req && mem_ack) begin
      wait_cnt  <= 0;
      cur_delay <= int'($urandom_range(0, 5));
      if (mem_we) begin
        mem_arr[mem_addr[7:4]] <= mem_wdata;
        wr_mask[mem_addr[7:4]] <= 1'b1;
      end
    end else if (mem_req) begin
      wait_cnt <= wait_cnt + 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Runs until every queued expected fill has appeared, checking order,
  // data and that each done_l2 pulse is a single cycle.
  task automatic drain(input int max_cyc);
    logic prev;
    int   n;
    prev = 1'b0;
    n    = 0;
    while (exp_q.size() > 0 && n < max_cyc) begin
      step();
      n++;
      if (done_l2) begin
        logic [31:0] e;
        e = exp_q.pop_front();
        chk("done_addr", done_addr, e);
        chk("fill_data", rdata_l2, exp_rd(e));
        chk("done_gap", prev, 1'b0);
      end
      prev = done_l2;
    end
    chk("drain_left", exp_q.size(), 0);
    step();
    chk("done_width", done_l2, 1'b0);
  endtask

  initial begin
    logic saw_req;
    logic saw_done;
    reset    = 1'b0;
    valid_l2 = 1'b0;
    rw_l2    = 1'b0;
    addr_l2  = '0;
    wdata_l2 = '0;

    // Reset state
    step();
    step();
    chk("rst_stall", stall_l2, 1'b0);
    chk("rst_done", done_l2, 1'b0);
    chk("rst_done_addr", done_addr, 32'h0);
    chk("rst_rdata", rdata_l2, 256'h0);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 256'h0);
    reset = 1'b1;
    step();

    // 1: single read, ack tied high; done in the cycle after E+2
    ack_force = 1'b1;
    valid_l2  = 1'b1;
    rw_l2     = 1'b0;
    addr_l2   = 32'h40;
    step();
    valid_l2 = 1'b0;
    chk("t1_stall", stall_l2, 1'b0);
    chk("t1_done_e0", done_l2, 1'b0);
    step();
    chk("t1_mem_req", mem_req, 1'b1);
    chk("t1_mem_we", mem_we, 1'b0);
    chk("t1_mem_addr", mem_addr, 32'h40);
    chk("t1_done_e1", done_l2, 1'b0);
    step();
    chk("t1_done", done_l2, 1'b1);
    chk("t1_done_addr", done_addr, 32'h40);
    chk("t1_rdata", rdata_l2, pat(32'h40));
    chk("t1_stall_b", stall_l2, 1'b0);
    step();
    chk("t1_done_off", done_l2, 1'b0);

    // 2: writeback then read of the same line
    valid_l2 = 1'b1;
    rw_l2    = 1'b1;
    addr_l2  = 32'h80;
    wdata_l2 = {8{32'hAAAA_5555}};
    step();
    rw_l2    = 1'b0;
    wdata_l2 = '0;
    step();
    valid_l2 = 1'b0;
    chk("t2_wb_req", mem_req, 1'b1);
    chk("t2_wb_we", mem_we, 1'b1);
    chk("t2_wb_addr", mem_addr, 32'h80);
    chk("t2_wb_data", mem_wdata, {8{32'hAAAA_5555}});
    chk("t2_wb_nodone", done_l2, 1'b0);
    step();
    chk("t2_idle_req", mem_req, 1'b0);
    chk("t2_idle_nodone", done_l2, 1'b0);
    step();
    chk("t2_rd_req", mem_req, 1'b1);
    chk("t2_rd_we", mem_we, 1'b0);
    step();
    chk("t2_done", done_l2, 1'b1);
    chk("t2_done_addr", done_addr, 32'h80);
    chk("t2_rdata", rdata_l2, {8{32'hAAAA_5555}});
    step();
    chk("t2_done_off", done_l2, 1'b0);

    // 3: fill the queue with ack held low; fifth request waits for a slot
    ack_force = 1'b0;
    valid_l2  = 1'b1;
    rw_l2     = 1'b0;
    for (int i = 0; i < 4; i++) begin
      addr_l2 = 32'h10 * (i + 1);
      step();
      chk($sformatf("t3_stall_%0d", i), stall_l2, (i == 3) ? 1'b1 : 1'b0);
    end
    addr_l2 = 32'h50;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("t3_held_stall", stall_l2, 1'b1);
      chk("t3_held_req", mem_req, 1'b1);
      chk("t3_held_addr", mem_addr, 32'h10);
    end
    ack_force = 1'b1;
    step();
    ack_force = 1'b0;
    chk("t3_free_stall", stall_l2, 1'b0);
    chk("t3_done", done_l2, 1'b1);
    chk("t3_done_addr", done_addr, 32'h10);
    step();
    valid_l2 = 1'b0;
    chk("t3_fifth_in", stall_l2, 1'b1);
    ack_force = 1'b1;
    exp_q = '{32'h20, 32'h30, 32'h40, 32'h50};
    drain(60);
    chk("t3_stall_end", stall_l2, 1'b0);

    // 4: reset mid-ISSUE flushes the queue
    ack_force = 1'b0;
    valid_l2  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      addr_l2 = 32'h10 * (i + 1);
      step();
    end
    valid_l2 = 1'b0;
    chk("t4_issue", mem_req, 1'b1);
    reset = 1'b0;
    #1;
    chk("t4_rst_req", mem_req, 1'b0);
    chk("t4_rst_done", done_l2, 1'b0);
    chk("t4_rst_stall", stall_l2, 1'b0);
    step();
    reset     = 1'b1;
    ack_force = 1'b1;
    saw_req   = 1'b0;
    saw_done  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      saw_req  = saw_req | mem_req;
      saw_done = saw_done | done_l2;
    end
    chk("t4_no_req", saw_req, 1'b0);
    chk("t4_no_done", saw_done, 1'b0);
    ack_force = 1'b0;

    // 5: three reads with random ack latency 0..5
    valid_l2 = 1'b1;
    rw_l2    = 1'b0;
    for (int i = 0; i < 3; i++) begin
      addr_l2 = 32'h10 * (i + 1);
      step();
    end
    valid_l2 = 1'b0;
    ack_rand = 1'b1;
    exp_q = '{32'h10, 32'h20, 32'h30};
    drain(80);
    ack_rand = 1'b0;

`ifdef L2_WB_FORWARD_EN
    // 6: read answered from the retired writeback, no memory read
    ack_force = 1'b1;
    valid_l2  = 1'b1;
    rw_l2     = 1'b1;
    addr_l2   = 32'h90;
    wdata_l2  = {8{32'hBBBB_0123}};
    step();
    valid_l2 = 1'b0;
    for (int i = 0; i < 3; i++) step();
    ack_force = 1'b0;
    valid_l2  = 1'b1;
    rw_l2     = 1'b0;
    step();
    valid_l2 = 1'b0;
    step();
    chk("t6_no_req", mem_req, 1'b0);
    exp_q = '{32'h90};
    drain(10);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
